ball_motion_sequencer: RTL

Synchronous per-frame motion controller for up to NUM_BALLS bouncing balls sharing one position/velocity register file and one step/bounce datapath. On each vsync rising edge it walks the balls one at a time, adds velocity, resolves wall bounces and writes back; renderers read positions through a combinational read port. Single clock domain, clk-driven throughout; vsync is an input to be sampled, never a clock.

---
 rtl/ball_pkg.sv | 33 +++
 rtl/ball_axis_step.sv | 36 +++
 rtl/ball_motion_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared constants, reset trajectory and sequencer state encoding for the
// ball motion sequencer and its axis-step datapath.
package ball_pkg;

  localparam int BALL_SIZE_DEF = 4;
  localparam int H_LIMIT_DEF   = 256;
  localparam int V_LIMIT_DEF   = 240;

  localparam int INIT_HPOS_BASE = 32;
  localparam int INIT_HPOS_STEP = 48;
  localparam int INIT_VPOS_BASE = 40;
  localparam int INIT_VPOS_STEP = 32;

  localparam logic [8:0] INIT_HVEL = 9'h1FE;  // -2
  localparam logic [8:0] INIT_VVEL = 9'h002;  // +2

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    WRITE,
    DONE
  } seq_state_e;

  function automatic logic [8:0] init_hpos(int i);
    return 9'(INIT_HPOS_BASE + INIT_HPOS_STEP * i);
  endfunction

  function automatic logic [8:0] init_vpos(int i);
    return 9'(INIT_VPOS_BASE + INIT_VPOS_STEP * i);
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-axis motion step: adds a two's-complement velocity to a position and
// reflects off the walls at 0 and max_i.
module ball_axis_step (
  input  logic [8:0] pos_i,
  input  logic [8:0] vel_i,
  input  logic [8:0] max_i,
  output logic [8:0] pos_o,
  output logic [8:0] vel_o,
  output logic       bounce_o
);

  logic [8:0] neg_vel;
  logic [9:0] wide_sum;

  assign neg_vel  = ~vel_i + 9'd1;
  assign wide_sum = {1'b0, pos_i} + {1'b0, vel_i};

  // NOTE: every output gets a default before the branches so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    pos_o    = wide_sum[8:0];
    vel_o    = vel_i;
    bounce_o = 1'b0;
    if (!vel_i[8] && (vel_i != 9'd0) && (wide_sum >= {1'b0, max_i})) begin
      pos_o    = max_i;
      vel_o    = neg_vel;
      bounce_o = 1'b1;
    end else if (vel_i[8] && (pos_i < neg_vel)) begin
      // Moving left/up by more than the distance to the wall: clamp, no wrap.
      pos_o    = 9'd0;
      vel_o    = neg_vel;
      bounce_o = 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_sequencer.sv
// Per-frame sequencer: on each synchronized vsync rise, steps every ball
// through one shared pair of axis-step units and writes the results back.
module ball_motion_sequencer
  import ball_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int BALL_SIZE = BALL_SIZE_DEF,
  parameter int H_LIMIT   = H_LIMIT_DEF,
  parameter int V_LIMIT   = V_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic                 pause,
  input  logic [2:0]           rd_idx,
  output logic [8:0]           rd_hpos,
  output logic [8:0]           rd_vpos,
  output logic                 busy,
  output logic [NUM_BALLS-1:0] bounce_h,
  output logic [NUM_BALLS-1:0] bounce_v,
  output logic                 overrun,
  output logic [15:0]          frame_count
);

  localparam logic [8:0] H_MAX    = 9'(H_LIMIT - BALL_SIZE);
  localparam logic [8:0] V_MAX    = 9'(V_LIMIT - BALL_SIZE);
  localparam logic [2:0] LAST_IDX = 3'(NUM_BALLS - 1);

  logic vs_meta_q, vs_sync_q, vs_prev_q, vs_rise;

  seq_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;

  logic [8:0] hpos_q [NUM_BALLS];
  logic [8:0] vpos_q [NUM_BALLS];
  logic [8:0] hvel_q [NUM_BALLS];
  logic [8:0] vvel_q [NUM_BALLS];

  logic [8:0] ld_hpos, ld_vpos, ld_hvel, ld_vvel;
  logic [8:0] wk_hpos_q, wk_vpos_q, wk_hvel_q, wk_vvel_q;
  logic [8:0] nx_hpos, nx_vpos, nx_hvel, nx_vvel;
  logic       nx_bh, nx_bv;
  logic [8:0] st_hpos_q, st_vpos_q, st_hvel_q, st_vvel_q;
  logic       st_bh_q, st_bv_q;

  logic [NUM_BALLS-1:0] bounce_h_d, bounce_h_q, bounce_v_d, bounce_v_q;
  logic                 overrun_q;
  logic [15:0]          frame_q;

  assign vs_rise = vs_sync_q & ~vs_prev_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE:  if (vs_rise && !pause) state_d = LOAD;
      LOAD:  state_d = STEP;
      STEP:  state_d = WRITE;
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = LOAD;
        end
      end
      DONE: begin
        idx_d   = 3'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared register-file read muxes: work-register load and renderer port.
  always_comb begin
    ld_hpos = '0;
    ld_vpos = '0;
    ld_hvel = '0;
    ld_vvel = '0;
    rd_hpos = '0;
    rd_vpos = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (idx_q == 3'(i)) begin
        ld_hpos = hpos_q[i];
        ld_vpos = vpos_q[i];
        ld_hvel = hvel_q[i];
        ld_vvel = vvel_q[i];
      end
      if (rd_idx == 3'(i)) begin
        rd_hpos = hpos_q[i];
        rd_vpos = vpos_q[i];
      end
    end
  end

  always_comb begin
    bounce_h_d = '0;
    bounce_v_d = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      bounce_h_d[i] = (state_q == WRITE) && (idx_q == 3'(i)) && st_bh_q;
      bounce_v_d[i] = (state_q == WRITE) && (idx_q == 3'(i)) && st_bv_q;
    end
  end

  ball_axis_step u_step_h (
    .pos_i    (wk_hpos_q),
    .vel_i    (wk_hvel_q),
    .max_i    (H_MAX),
    .pos_o    (nx_hpos),
    .vel_o    (nx_hvel),
    .bounce_o (nx_bh)
  );

  ball_axis_step u_step_v (
    .pos_i    (wk_vpos_q),
    .vel_i    (wk_vvel_q),
    .max_i    (V_MAX),
    .pos_o    (nx_vpos),
    .vel_o    (nx_vvel),
    .bounce_o (nx_bv)
  );

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples its inputs from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_meta_q  <= 1'b0;
      vs_sync_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      bounce_h_q <= '0;
      bounce_v_q <= '0;
      overrun_q  <= 1'b0;
      frame_q    <= 16'd0;
    end else begin
      vs_meta_q  <= vsync;
      vs_sync_q  <= vs_meta_q;
      vs_prev_q  <= vs_sync_q;
      state_q    <= state_d;
      idx_q      <= idx_d;
      bounce_h_q <= bounce_h_d;
      bounce_v_q <= bounce_v_d;
      if (vs_rise && (state_q != IDLE)) overrun_q <= 1'b1;
      if (state_q == DONE) frame_q <= frame_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wk_hpos_q <= '0;
      wk_vpos_q <= '0;
      wk_hvel_q <= '0;
      wk_vvel_q <= '0;
      st_hpos_q <= '0;
      st_vpos_q <= '0;
      st_hvel_q <= '0;
      st_vvel_q <= '0;
      st_bh_q   <= 1'b0;
      st_bv_q   <= 1'b0;
    end else begin
      if (state_q == LOAD) begin
        wk_hpos_q <= ld_hpos;
        wk_vpos_q <= ld_vpos;
        wk_hvel_q <= ld_hvel;
        wk_vvel_q <= ld_vvel;
      end
      if (state_q == STEP) begin
        st_hpos_q <= nx_hpos;
        st_vpos_q <= nx_vpos;
        st_hvel_q <= nx_hvel;
        st_vvel_q <= nx_vvel;
        st_bh_q   <= nx_bh;
        st_bv_q   <= nx_bv;
      end
    end
  end

  // NOTE: the register file is reset because every ball has a defined start
  // trajectory; a reset mid-pass must restore all of it at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        hpos_q[i] <= init_hpos(i);
        vpos_q[i] <= init_vpos(i);
        hvel_q[i] <= INIT_HVEL;
        vvel_q[i] <= INIT_VVEL;
      end
    end else if (state_q == WRITE) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (idx_q == 3'(i)) begin
          hpos_q[i] <= st_hpos_q;
          vpos_q[i] <= st_vpos_q;
          hvel_q[i] <= st_hvel_q;
          vvel_q[i] <= st_vvel_q;
        end
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign bounce_h    = bounce_h_q;
  assign bounce_v    = bounce_v_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_q;

endmodule
